// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit word per line.
//   Build option: define ICACHE_PERF_EN to add hit_count/miss_count outputs.
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (0 = pause), flush_signal
//   fetch_en/fetch_addr in, fetch_ready/fetch_inst out (1-cycle pulse)
//   mem_query_en/mem_head_addr out, mem_block_en/mem_block_data in
//   hit_count/miss_count out (ICACHE_PERF_EN only)
module icache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_signal,
    input  logic        fetch_en,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic        mem_query_en,
    output logic [31:0] mem_head_addr,
    input  logic        mem_block_en,
    input  logic [31:0] mem_block_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

    typedef enum logic {IDLE, WAIT_MEM} state_t;
    state_t state, state_next;

    logic [LINES-1:0]     valid;
    logic [TAG_WIDTH-1:0] tags [LINES];
    logic [31:0]          data [LINES];

    logic [INDEX_WIDTH-1:0] fetch_idx, fill_idx;
    logic [TAG_WIDTH-1:0]   fetch_tag, fill_tag;
    logic hit, lookup, idle_hit, idle_miss, fill;
    logic unused_offset;

    assign unused_offset = ^fetch_addr[1:0];
    assign fetch_idx = fetch_addr[INDEX_WIDTH+1:2];
    assign fetch_tag = fetch_addr[31:INDEX_WIDTH+2];
    // mem_head_addr doubles as the latched miss address while in WAIT_MEM
    assign fill_idx  = mem_head_addr[INDEX_WIDTH+1:2];
    assign fill_tag  = mem_head_addr[31:INDEX_WIDTH+2];
    assign hit       = valid[fetch_idx] && tags[fetch_idx] == fetch_tag;
    assign lookup    = state == IDLE && fetch_en && !flush_signal;
    assign idle_hit  = lookup && hit;
    assign idle_miss = lookup && !hit;
    assign fill      = state == WAIT_MEM && mem_block_en && !flush_signal;

    always_comb begin
        state_next = state;
        state_next = (flush_signal || fill) ? IDLE : idle_miss ? WAIT_MEM : state;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in)
            state <= IDLE;
        else if (rdy_in)
            state <= state_next;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid         <= '0;
            fetch_ready   <= 1'b0;
            fetch_inst    <= '0;
            mem_query_en  <= 1'b0;
            mem_head_addr <= '0;
        end else if (rdy_in) begin
            fetch_ready   <= idle_hit || fill;
            fetch_inst    <= idle_hit ? data[fetch_idx] : fill ? mem_block_data : fetch_inst;
            mem_query_en  <= idle_miss || (mem_query_en && !fill && !flush_signal);
            mem_head_addr <= idle_miss ? {fetch_addr[31:2], 2'b00} : mem_head_addr;
            if (fill)
                valid[fill_idx] <= 1'b1;
        end
    end

    // tag/data storage needs no reset: the valid bits qualify it
    always_ff @(posedge clk_in) begin
        if (rst_in && rdy_in && fill) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= mem_block_data;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy_in) begin
            hit_count  <= hit_count + {31'd0, idle_hit};
            miss_count <= miss_count + {31'd0, idle_miss};
        end
    end
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: scoreboard bench for icache; fetch results queued at issue, checked on fetch_ready.
module tb_icache;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_signal, fetch_en, mem_block_en;
    logic [31:0] fetch_addr, mem_block_data;
    logic        fetch_ready, mem_query_en;
    logic [31:0] fetch_inst, mem_head_addr;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] sb_q[$];

    icache dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_inst(fetch_inst), .mem_query_en(mem_query_en), .mem_head_addr(mem_head_addr),
        .mem_block_en(mem_block_en), .mem_block_data(mem_block_data)
`ifdef ICACHE_PERF_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in)
        if (fetch_ready) begin
            if (sb_q.size() == 0)
                check("unexpected_ready", 32'd1, 32'd0);
            else
                check("fetch_inst", fetch_inst, sb_q.pop_front());
        end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] word, input int delay);
        fetch_en = 1'b1;
        fetch_addr = addr;
        tick();
        check("miss_query", {31'd0, mem_query_en}, 32'd1);
        check("miss_head", mem_head_addr, {addr[31:2], 2'b00});
        repeat (delay) tick();
        check("miss_hold", {31'd0, mem_query_en}, 32'd1);
        mem_block_en = 1'b1;
        mem_block_data = word;
        sb_q.push_back(word);
        tick();
        check("fill_ready", {31'd0, fetch_ready}, 32'd1);
        check("fill_query_drop", {31'd0, mem_query_en}, 32'd0);
        mem_block_en = 1'b0;
        fetch_en = 1'b0;
        tick();
        check("fill_pulse_end", {31'd0, fetch_ready}, 32'd0);
    endtask

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] word);
        fetch_en = 1'b1;
        fetch_addr = addr;
        sb_q.push_back(word);
        tick();
        check("hit_ready", {31'd0, fetch_ready}, 32'd1);
        check("hit_no_query", {31'd0, mem_query_en}, 32'd0);
        fetch_en = 1'b0;
        tick();
        check("hit_pulse_end", {31'd0, fetch_ready}, 32'd0);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_signal = 1'b0; fetch_en = 1'b0;
        fetch_addr = '0; mem_block_en = 1'b0; mem_block_data = '0;
        repeat (2) tick();
        check("rst_ready", {31'd0, fetch_ready}, 32'd0);
        check("rst_inst", fetch_inst, 32'd0);
        check("rst_query", {31'd0, mem_query_en}, 32'd0);
        check("rst_head", mem_head_addr, 32'd0);
        rst_in = 1'b1;
        tick();

        fetch_miss(32'h0000_0012, 32'h00A0_0093, 6);
        fetch_hit(32'h0000_0010, 32'h00A0_0093);
        fetch_miss(32'h0000_0110, 32'h0000_0013, 2);
        fetch_miss(32'h0000_0010, 32'h00A0_0093, 1);
`ifdef ICACHE_PERF_EN
        check("hit_count", hit_count, 32'd1);
        check("miss_count", miss_count, 32'd3);
`endif
        fetch_hit(32'h0000_0013, 32'h00A0_0093);
        fetch_miss(32'h0000_0200, 32'hDEAD_BEEF, 0);
        fetch_hit(32'h0000_0200, 32'hDEAD_BEEF);

        // fetch_en held high in IDLE issues back-to-back hits
        fetch_en = 1'b1;
        fetch_addr = 32'h0000_0010;
        sb_q.push_back(32'h00A0_0093);
        sb_q.push_back(32'h00A0_0093);
        tick();
        check("b2b_ready0", {31'd0, fetch_ready}, 32'd1);
        tick();
        check("b2b_ready1", {31'd0, fetch_ready}, 32'd1);
        fetch_en = 1'b0;
        tick();

        // mem_block_en in IDLE is ignored
        mem_block_en = 1'b1;
        mem_block_data = 32'h7777_7777;
        tick();
        check("idle_blk_ready", {31'd0, fetch_ready}, 32'd0);
        check("idle_blk_query", {31'd0, mem_query_en}, 32'd0);
        mem_block_en = 1'b0;
        fetch_hit(32'h0000_0200, 32'hDEAD_BEEF);

        // flush coinciding with the block return discards the fill
        fetch_en = 1'b1;
        fetch_addr = 32'h0000_0300;
        tick();
        check("fl_query", {31'd0, mem_query_en}, 32'd1);
        tick();
        mem_block_en = 1'b1;
        mem_block_data = 32'h1111_1111;
        flush_signal = 1'b1;
        tick();
        check("fl_query_clr", {31'd0, mem_query_en}, 32'd0);
        check("fl_ready_clr", {31'd0, fetch_ready}, 32'd0);
        flush_signal = 1'b0;
        mem_block_en = 1'b0;
        fetch_en = 1'b0;
        tick();
        check("fl_idle", {31'd0, fetch_ready | mem_query_en}, 32'd0);
        fetch_miss(32'h0000_0300, 32'h2222_2222, 1);

        // pause in WAIT_MEM holds everything and ignores the block
        fetch_en = 1'b1;
        fetch_addr = 32'h0000_0400;
        tick();
        check("pz_query", {31'd0, mem_query_en}, 32'd1);
        rdy_in = 1'b0;
        mem_block_en = 1'b1;
        mem_block_data = 32'h5555_5555;
        fetch_addr = 32'h0000_0800;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pz_hold_query", {31'd0, mem_query_en}, 32'd1);
            check("pz_hold_ready", {31'd0, fetch_ready}, 32'd0);
            check("pz_hold_head", mem_head_addr, 32'h0000_0400);
        end
        rdy_in = 1'b1;
        mem_block_data = 32'h6666_6666;
        sb_q.push_back(32'h6666_6666);
        tick();
        check("pz_fill_ready", {31'd0, fetch_ready}, 32'd1);
        check("pz_fill_query", {31'd0, mem_query_en}, 32'd0);
        mem_block_en = 1'b0;
        fetch_en = 1'b0;
        tick();

        // reset mid-miss abandons the request and invalidates the cache
        fetch_en = 1'b1;
        fetch_addr = 32'h0000_0500;
        tick();
        check("rm_query", {31'd0, mem_query_en}, 32'd1);
        rst_in = 1'b0;
        tick();
        check("rm_ready", {31'd0, fetch_ready}, 32'd0);
        check("rm_inst", fetch_inst, 32'd0);
        check("rm_query_clr", {31'd0, mem_query_en}, 32'd0);
        check("rm_head", mem_head_addr, 32'd0);
        rst_in = 1'b1;
        fetch_en = 1'b0;
        tick();
        fetch_miss(32'h0000_0010, 32'h00A0_0093, 1);

        repeat (2) tick();
        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
